// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
// The core drives requests (master); the unit answers with a one-cycle response (slave).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req_valid, req_write, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, fault
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, fault
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I byte-addressed load/store front end for a 4096x32 word RAM without byte enables.
// Sub-word stores are done as read-modify-write; misaligned/illegal requests fault at accept.
module load_store_unit (
  input  logic                     clk,
  input  logic                     rst,
  load_store_unit_if.slave         core,
  output logic [11:0]              mem_address,
  output logic [31:0]              mem_data_input,
  output logic                     mem_store,
  output logic                     mem_load,
  input  logic [31:0]              mem_data_output
);

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    ST_WR,
    RMW_RD,
    RMW_WR
  } state_t;

  state_t      state;
  logic        l_write;
  logic [2:0]  l_funct3;
  logic [13:0] l_addr;
  logic [31:0] l_wdata;
  logic        resp_valid_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic        req_fault;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^core.addr[31:14];

  function automatic logic check_fault(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return off[0];
      3'b010:  return off != 2'b00;
      3'b100:  return wr;
      3'b101:  return wr | off[0];
      default: return 1'b1;
    endcase
  endfunction

  assign req_fault = check_fault(core.req_write, core.funct3, core.addr[1:0]);

  always_comb begin
    sel_byte = mem_data_output[{l_addr[1:0], 3'b000} +: 8];
    sel_half = mem_data_output[{l_addr[1], 4'b0000} +: 16];
    case (l_funct3)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_ext = {24'h000000, sel_byte};
      3'b101:  load_ext = {16'h0000, sel_half};
      default: load_ext = mem_data_output;
    endcase
  end

  always_comb begin
    merged = mem_data_output;
    if (l_funct3[0])
      merged[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
    else
      merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      l_write      <= 1'b0;
      l_funct3     <= '0;
      l_addr       <= '0;
      l_wdata      <= '0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (core.req_valid) begin
            l_write  <= core.req_write;
            l_funct3 <= core.funct3;
            l_addr   <= core.addr[13:0];
            l_wdata  <= core.wdata;
            if (req_fault) begin
              resp_valid_q <= 1'b1;
              fault_q      <= 1'b1;
              rdata_q      <= '0;
            end else if (core.req_write) begin
              state <= (core.funct3 == 3'b010) ? ST_WR : RMW_RD;
            end else begin
              state <= LD_REQ;
            end
          end
        end
        LD_REQ:  state <= LD_WAIT;
        LD_WAIT: begin
          rdata_q      <= load_ext;
          resp_valid_q <= 1'b1;
          state        <= IDLE;
        end
        RMW_RD:  state <= RMW_WR;
        ST_WR, RMW_WR: begin
          rdata_q      <= '0;
          resp_valid_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state but gated by rst so a reset edge never commits a write.
  assign mem_load       = !rst && (state == LD_REQ || state == RMW_RD);
  assign mem_store      = !rst && l_write && (state == ST_WR || state == RMW_WR);
  assign mem_address    = l_addr[13:2];
  assign mem_data_input = (state == RMW_WR) ? merged : l_wdata;

  assign core.req_ready  = (state == IDLE);
  assign core.resp_valid = resp_valid_q;
  assign core.fault      = fault_q;
  assign core.rdata      = rdata_q;

endmodule
